store_size_unit: RTL and testbench
==================================

// Module: store_size_unit
// PURPOSE
//  Write-side partner of the load-size path (SetSize). Executes sw/sh/sb into the
//  byte-addressed Memoria on the control unit's request. sh/sb are read-modify-write:
//  read the word at addr, merge the low half/byte of store_data, write the word back.
//  Sits between ctrl_unit (start/done handshake) and the memory port (memAddr, WriteMem, MemDataIn).
// PARAMETERS
//  MEM_LAT   1   cycles from address presented to rdata valid (Memoria = 1); range 1..7
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset       in   1   asynchronous, active-high; returns block to IDLE
//  start       in   1   request pulse; sampled only in IDLE
//  size        in   2   00 word (sw), 01 half (sh), 10 byte (sb), 11 reserved
//  addr        in   32  target byte address (ALUOut)
//  store_data  in   32  data to store (B)
//  mem_rdata   in   32  Memoria read data (MemDataOut)
//  mem_addr    out  32  address to memory address mux
//  mem_wr      out  1   memory write enable (WriteMem)
//  mem_wdata   out  32  memory write data (MemDataIn)
//  busy        out  1   1 whenever state != IDLE
//  done        out  1   one-cycle completion pulse
//  size_err    out  1   valid with done; 1 if size==11
// BEHAVIOUR
//  - Reset (async): state=IDLE; mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, done=0, size_err=0.
//  - FSM states: IDLE, READ, WRITE, DONE.
//  - IDLE: on start=1 latch addr_q, size_q, data_q. size 00 -> WRITE with mem_wdata=data_q;
//    01/10 -> READ; 11 -> DONE with size_err=1 (no memory write).
//  - READ: mem_addr=addr_q, mem_wr=0; held MEM_LAT+1 cycles (3-bit down-counter);
//    on the last READ cycle sample mem_rdata, form merged word, load mem_wdata -> WRITE.
//  - Merge (lane 0 = low-order bits, matching the load-size convention):
//    half: {rdata[31:16], data_q[15:0]}; byte: {rdata[31:8], data_q[7:0]}. addr LSBs do not select lanes.
//  - WRITE: mem_addr=addr_q, mem_wr=1 for exactly one cycle -> DONE.
//  - DONE: done=1 for one cycle, size_err as latched, mem_wr=0 -> IDLE.
//  - Latency (start-sampling edge to done high): word 2 cycles; half/byte MEM_LAT+3; reserved 1.
//  - mem_addr=0 in IDLE and DONE; mem_wdata holds its last value until next load.
//  - start while busy: ignored, no queuing. Inputs other than mem_rdata are don't-care after latch.
//  - start in the DONE cycle: ignored (only IDLE samples start); back-to-back stores need one idle cycle.
//  - reset mid-operation: immediate IDLE; mem_wr drops asynchronously, aborted write never issued.
//  - mem_wr is never 1 outside WRITE; exactly one write per accepted sw/sh/sb.
// STRUCTURE
//  - Shared header store_size_defs.vh: size encodings (SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD)
//    and FSM state encodings; the load-size path includes the same size codes.
//  - One combinational sub-module: byte_lane_merge (size, rdata, wdata -> merged word).
//  - Top: FSM, latency counter, latch registers, output registers/decoding.
// TESTING
//  - sw: addr=0x40, data=0xDEADBEEF -> done at +2; one mem_wr at 0x40 with 0xDEADBEEF; no read phase.
//  - sh: mem[0x40]=0x11223344, data=0xAAAA5566 -> write 0x11225566 at 0x40; done at +4 (MEM_LAT=1).
//  - sb: mem[0x44]=0xCAFEBABE, data=0x000000FF -> write 0xCAFEBAFF; done at +4; size_err=0.
//  - size=11, addr=0x48 -> done at +1 with size_err=1; mem_wr never asserted; memory unchanged.
//  - start pulsed again during READ of an sb -> ignored; exactly one write, one done.
//  - reset asserted during READ of sh -> busy=0 and mem_wr=0 immediately; memory unchanged;
//    new sw after release completes normally in 2 cycles.

Source files
------------

// File: rtl/store_size_unit_pkg.sv
// ----------------------------------------------------------------------------
// store_size_unit_pkg : size codes and FSM states shared by the store-size path
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package store_size_unit_pkg;

   // Same encodings the load-size path uses
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/store_size_unit_byte_lane_merge.sv
// ----------------------------------------------------------------------------
// byte_lane_merge : overlays the low half/byte of wdata onto a read word
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module byte_lane_merge
   import store_size_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] merged
);

   // Lane 0 is always the low-order bits; the address does not select a lane.
   always_comb begin
      merged = wdata;
      case (size)
         SZ_HALF: merged = {rdata[31:16], wdata[15:0]};
         SZ_BYTE: merged = {rdata[31:8],  wdata[7:0]};
         default: merged = wdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/store_size_unit.sv
// ----------------------------------------------------------------------------
// store_size_unit : executes sw/sh/sb; sh/sb are read-modify-write sequences
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_size_unit
   import store_size_unit_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        size_err
);

   localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, data_q, wdata_q;
   logic [31:0] merged;

   byte_lane_merge u_merge (
      .size   (size_q),
      .rdata  (mem_rdata),
      .wdata  (data_q),
      .merged (merged)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         size_q  <= SZ_WORD;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            size_q <= size;
            addr_q <= addr;
            data_q <= store_data;
            cnt_q  <= LAT_LOAD;
            if (size == SZ_WORD)
               wdata_q <= store_data;
         end else if (state_q == ST_READ) begin
            // Read data is valid on the last of the MEM_LAT+1 read cycles
            if (cnt_q != 3'd0)
               cnt_q <= cnt_q - 3'd1;
            else
               wdata_q <= merged;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      mem_addr = 32'd0;
      mem_wr   = 1'b0;
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      size_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (size)
                  SZ_WORD: state_d = ST_WRITE;
                  SZ_RSVD: state_d = ST_DONE;
                  default: state_d = ST_READ;
               endcase
            end
         end
         ST_READ: begin
            mem_addr = addr_q;
            if (cnt_q == 3'd0)
               state_d = ST_WRITE;
         end
         ST_WRITE: begin
            mem_addr = addr_q;
            mem_wr   = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            size_err = (size_q == SZ_RSVD);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_store_size_unit.sv
// ----------------------------------------------------------------------------
// tb_store_size_unit : vector table plus corner sequences with a write scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_store_size_unit;
   import store_size_unit_pkg::*;

   localparam int MEM_LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr, store_data, mem_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_wr, busy, done, size_err;

   store_size_unit #(.MEM_LAT(MEM_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .size       (size),
      .addr       (addr),
      .store_data (store_data),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .size_err   (size_err)
   );

   always #5 clk = ~clk;

   // One-cycle-latency word memory
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (mem_wr === 1'b1) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] init;
      logic [31:0] final_word;
      int          lat;
      logic        err;
   } vec_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   checks = 0;
   int   errors = 0;
   int   wr_count = 0;

   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d) begin
               errors++;
               $display("FAIL write_sb got addr=%h data=%h want addr=%h data=%h",
                        mem_addr, mem_wdata, mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input bit repulse, output int cyc);
      @(negedge clk);
      start = 1'b1; size = sz; addr = a; store_data = d;
      @(negedge clk);
      size = 2'($urandom); addr = $urandom; store_data = $urandom;
      cyc = 1;
      while (done !== 1'b1 && cyc < 30) begin
         start = repulse && (cyc == 1);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   vec_t vecs [6];
   int   cyc;
   int   w0;
   int   dones;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      vecs[0] = '{SZ_WORD, 32'h40, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2,           1'b0};
      vecs[1] = '{SZ_HALF, 32'h40, 32'hAAAA5566, 32'h11223344, 32'h11225566, MEM_LAT + 3, 1'b0};
      vecs[2] = '{SZ_BYTE, 32'h44, 32'h000000FF, 32'hCAFEBABE, 32'hCAFEBAFF, MEM_LAT + 3, 1'b0};
      vecs[3] = '{SZ_RSVD, 32'h48, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1,           1'b1};
      vecs[4] = '{SZ_HALF, 32'h4C, 32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000, MEM_LAT + 3, 1'b0};
      vecs[5] = '{SZ_BYTE, 32'h4A, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A578, MEM_LAT + 3, 1'b0};

      reset = 1'b1; start = 1'b0; size = 2'd0; addr = 32'd0; store_data = 32'd0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_size_err", 32'(size_err), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         mem[vecs[i].a[7:2]] = vecs[i].init;
         if (vecs[i].sz != SZ_RSVD) exp_q.push_back('{vecs[i].a, vecs[i].final_word});
         run_store(vecs[i].sz, vecs[i].a, vecs[i].d, 1'b0, cyc);
         check($sformatf("latency_%0d", i), 32'(cyc), 32'(vecs[i].lat));
         check($sformatf("size_err_%0d", i), 32'(size_err), 32'(vecs[i].err));
         check($sformatf("mem_%0d", i), mem[vecs[i].a[7:2]], vecs[i].final_word);
         check($sformatf("sb_drained_%0d", i), 32'(exp_q.size()), 32'd0);
         @(negedge clk);
         check($sformatf("done_pulse_%0d", i), 32'(done), 32'd0);
         check($sformatf("idle_busy_%0d", i), 32'(busy), 32'd0);
      end

      // Second start during the read phase of a byte store must be ignored
      mem[6'h11] = 32'hCAFEBABE;
      w0 = wr_count;
      exp_q.push_back('{32'h44, 32'hCAFEBAAB});
      run_store(SZ_BYTE, 32'h44, 32'h000000AB, 1'b1, cyc);
      check("repulse_latency", 32'(cyc), 32'(MEM_LAT + 3));
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("repulse_extra_done", 32'(dones), 32'd0);
      check("repulse_writes", 32'(wr_count - w0), 32'd1);
      check("repulse_mem", mem[6'h11], 32'hCAFEBAAB);

      // Reset in the middle of a half store aborts it without a write
      mem[6'h10] = 32'h11223344;
      w0 = wr_count;
      @(negedge clk);
      start = 1'b1; size = SZ_HALF; addr = 32'h40; store_data = 32'hAAAA5566;
      @(negedge clk);
      start = 1'b0;
      check("pre_reset_busy", 32'(busy), 32'd1);
      check("read_mem_addr", mem_addr, 32'h40);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mem_wr", 32'(mem_wr), 32'd0);
      check("abort_mem_addr", mem_addr, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      check("abort_writes", 32'(wr_count - w0), 32'd0);
      check("abort_mem", mem[6'h10], 32'h11223344);

      exp_q.push_back('{32'h50, 32'h0BADF00D});
      run_store(SZ_WORD, 32'h50, 32'h0BADF00D, 1'b0, cyc);
      check("post_reset_latency", 32'(cyc), 32'd2);
      check("post_reset_mem", mem[6'h14], 32'h0BADF00D);

      repeat (3) @(negedge clk);
      check("sb_final_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
